ram_ring_cache: RTL

RAM_RING_CACHE -- requirements
Module: ram_ring_cache

---
 rtl/ram_ring_cache.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ram_ring_cache.sv
// ram_ring_cache: circular capture RAM on wrclock, triggered burst replay of the newest BURST_LEN words on rdclock.
// Optional: define RING_CACHE_DROP_CNT_EN to count triggers that arrive while a burst is already running.
module ram_ring_cache #(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 8,
    parameter int         BURST_LEN = 256,
    parameter logic [3:0] CAP_STATE = 4'd6
) (
    input  logic              wrclock,
    input  logic              rdclock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        usb_rd_state,
    input  logic              trig_n,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   fill,
    output logic [7:0]        drop_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BACK = ADDR_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr, wnext, wgray, gs1, gs2, ws, snap, raddr;
    logic [ADDR_W:0]   cnt;
    logic              t1, t2, t3, trig, cap;
    state_t            state, nstate;

    assign cap   = usb_rd_state == CAP_STATE;
    assign wnext = wptr + 1'b1;
    assign trig  = t3 & ~t2;

    // Capture port; no reset so stored words survive rst_n.
    always_ff @(posedge wrclock)
        if (cap) mem[wptr] <= data;

    // Write pointer, its Gray copy for the crossing, and saturating fill level.
    always_ff @(posedge wrclock or negedge rst_n)
        if (!rst_n) begin
            wptr  <= '0;
            wgray <= '0;
            fill  <= '0;
        end else if (cap) begin
            wptr  <= wnext;
            wgray <= wnext ^ (wnext >> 1);
            if (fill != FULL) fill <= fill + 1'b1;
        end

    // Synchronise Gray pointer and trigger into rdclock; trigger idles high so reset causes no edge.
    always_ff @(posedge rdclock or negedge rst_n)
        if (!rst_n) begin
            gs1          <= '0;
            gs2          <= '0;
            {t1, t2, t3} <= 3'b111;
        end else begin
            gs1          <= wgray;
            gs2          <= gs1;
            {t1, t2, t3} <= {trig_n, t1, t2};
        end

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        ws = '0;
        for (int i = 0; i < ADDR_W; i++) ws[i] = ^(gs2 >> i);
    end

    // Read FSM state register.
    always_ff @(posedge rdclock or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nstate;

    // Read FSM next state and status outputs.
    always_comb begin
        nstate = state;
        busy   = state != IDLE;
        done   = state == DONE;
        case (state)
            IDLE:    nstate = trig ? LOAD : IDLE;
            LOAD:    nstate = READ;
            READ:    nstate = (cnt == LAST) ? DONE : READ;
            default: nstate = IDLE;
        endcase
    end

    // Snapshot, start address (modulo wrap makes a full-depth burst start at the snapshot) and word count.
    always_ff @(posedge rdclock or negedge rst_n)
        if (!rst_n) begin
            snap  <= '0;
            raddr <= '0;
            cnt   <= '0;
        end else begin
            if (state == IDLE && trig) snap <= ws;
            if (state == LOAD) begin
                raddr <= snap - BACK;
                cnt   <= '0;
            end else if (state == READ) begin
                raddr <= raddr + 1'b1;
                cnt   <= cnt + 1'b1;
            end
        end

    // Registered read port; q holds its value between bursts.
    always_ff @(posedge rdclock or negedge rst_n)
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= state == READ;
            if (state == READ) q <= mem[raddr];
        end

`ifdef RING_CACHE_DROP_CNT_EN
    logic [7:0] drops;
    // Count triggers ignored because a burst is running, saturating at 255.
    always_ff @(posedge rdclock or negedge rst_n)
        if (!rst_n) drops <= '0;
        else if (trig && state != IDLE && drops != 8'hFF) drops <= drops + 1'b1;
    assign drop_cnt = drops;
`else
    assign drop_cnt = '0;
`endif
endmodule
